// File: rtl/kronos_imem_responder.sv
// Purpose: instruction-fetch responder over a word RAM, with a side-band program-load port.
// Latency: grant WAIT_STATES+1 cycles after a request is captured; 1 word/cycle streaming at WAIT_STATES=0.
// Backpressure: none; a grant is a one-cycle pulse and an unconsumed word is simply dropped.
module kronos_imem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] FAULT_DATA  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rstz,
    input  logic [31:0] instr_addr,
    input  logic        instr_req,
    output logic        instr_gnt,
    output logic [31:0] instr_data,
    output logic        fetch_fault,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int unsigned IW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WS      = WAIT_STATES[3:0];
    localparam logic [31:0] DEPTH32 = DEPTH_WORDS;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    // Range check is done on the full 32-bit offset before any truncation,
    // so out-of-range addresses can never alias onto a valid word.
    function automatic logic addr_bad(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return (a[1:0] != 2'b00) || (a < BASE_ADDR) || ({2'b00, off[31:2]} >= DEPTH32);
    endfunction

    function automatic logic [IW-1:0] addr_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return off[IW+1:2];
    endfunction

    logic [31:0] mem [DEPTH_WORDS];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [IW-1:0] cap_idx_q, cap_idx_d;
    logic        cap_fault_q, cap_fault_d;
    logic        gnt_q, gnt_d;
    logic [31:0] data_q, data_d;
    logic        fault_q, fault_d;

    logic          rd_en;
    logic [IW-1:0] rd_idx;
    logic          rd_fault;
    logic          accept;

    // Next-state, capture and registered-read selection for the fetch FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cap_idx_d   = cap_idx_q;
        cap_fault_d = cap_fault_q;
        data_d      = data_q;
        gnt_d       = 1'b0;
        fault_d     = 1'b0;
        rd_en       = 1'b0;
        rd_idx      = cap_idx_q;
        rd_fault    = cap_fault_q;
        accept      = instr_req && ((state_q == ST_IDLE) || (state_q == ST_RESP));

        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (accept) begin
                    cap_idx_d   = addr_idx(instr_addr);
                    cap_fault_d = addr_bad(instr_addr);
                    if (WS == 4'd0) begin
                        // Zero wait: the read happens on the capture edge itself.
                        state_d  = ST_RESP;
                        rd_en    = 1'b1;
                        rd_idx   = addr_idx(instr_addr);
                        rd_fault = addr_bad(instr_addr);
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WS - 4'd1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    rd_en   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The array is sampled before this edge's load lands, giving read-first collisions.
        if (rd_en) begin
            gnt_d   = 1'b1;
            data_d  = rd_fault ? FAULT_DATA : mem[rd_idx];
            fault_d = rd_fault;
        end
    end

    // FSM state and registered outputs; reset drops any in-flight request.
    always_ff @(posedge clk) begin
        if (!rstz) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            cap_idx_q   <= '0;
            cap_fault_q <= 1'b0;
            gnt_q       <= 1'b0;
            data_q      <= 32'h0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cap_idx_q   <= cap_idx_d;
            cap_fault_q <= cap_fault_d;
            gnt_q       <= gnt_d;
            data_q      <= data_d;
            fault_q     <= fault_d;
        end
    end

    // Program-load writes; accepted in any state and independent of reset.
    always_ff @(posedge clk) begin
        if (load_en && !addr_bad(load_addr)) begin
            mem[addr_idx(load_addr)] <= load_data;
        end
    end

    assign instr_gnt   = gnt_q;
    assign instr_data  = data_q;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_kronos_imem_responder.sv
module tb_kronos_imem_responder;

    logic        clk;
    logic        rstz;
    logic [31:0] addr;
    logic        req;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;

    logic [2:0]       gnt;
    logic [2:0][31:0] dat;
    logic [2:0]       flt;

    int total = 0;
    int bad   = 0;
    bit chk_on = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Three configurations: (BASE 0, W=0), (BASE 0, W=2), (BASE 0x100, W=3).
    kronos_imem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0), .FAULT_DATA(32'h13)) u_d0 (
        .clk(clk), .rstz(rstz), .instr_addr(addr), .instr_req(req),
        .instr_gnt(gnt[0]), .instr_data(dat[0]), .fetch_fault(flt[0]),
        .load_en(ld_en), .load_addr(ld_addr), .load_data(ld_data));
    kronos_imem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(2), .FAULT_DATA(32'h13)) u_d1 (
        .clk(clk), .rstz(rstz), .instr_addr(addr), .instr_req(req),
        .instr_gnt(gnt[1]), .instr_data(dat[1]), .fetch_fault(flt[1]),
        .load_en(ld_en), .load_addr(ld_addr), .load_data(ld_data));
    kronos_imem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h100), .WAIT_STATES(3), .FAULT_DATA(32'h13)) u_d2 (
        .clk(clk), .rstz(rstz), .instr_addr(addr), .instr_req(req),
        .instr_gnt(gnt[2]), .instr_data(dat[2]), .fetch_fault(flt[2]),
        .load_en(ld_en), .load_addr(ld_addr), .load_data(ld_data));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    function automatic logic [31:0] mbase(input int i);
        return (i == 2) ? 32'h100 : 32'h0;
    endfunction
    function automatic int mwait(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 2 : 3);
    endfunction
    function automatic bit mbad(input logic [31:0] a, input logic [31:0] base);
        logic [31:0] off;
        off = a - base;
        return (a[1:0] != 2'b00) || (a < base) || ((off >> 2) >= 32'd1024);
    endfunction
    function automatic int midx(input logic [31:0] a, input logic [31:0] base);
        logic [31:0] off;
        off = (a - base) >> 2;
        return int'(off);
    endfunction

    bit [31:0]   mmem [3][1024];
    bit          pend [3];
    int          rem  [3];
    logic [31:0] cap  [3];
    logic        eg   [3];
    logic [31:0] ed   [3];
    logic        ef   [3];

    // Each request is one outstanding transaction that completes W edges after capture.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            bit fire;
            fire = 0;
            if (!rstz) begin
                pend[i] = 0; eg[i] = 0; ed[i] = 32'h0; ef[i] = 0;
            end else begin
                eg[i] = 0; ef[i] = 0;
                if (pend[i]) begin
                    rem[i]--;
                    if (rem[i] == 0) begin fire = 1; pend[i] = 0; end
                end else if (req) begin
                    cap[i] = addr;
                    if (mwait(i) == 0) fire = 1;
                    else begin pend[i] = 1; rem[i] = mwait(i); end
                end
                if (fire) begin
                    eg[i] = 1;
                    if (mbad(cap[i], mbase(i))) begin ed[i] = 32'h13; ef[i] = 1; end
                    else ed[i] = mmem[i][midx(cap[i], mbase(i))];
                end
            end
            if (ld_en && !mbad(ld_addr, mbase(i)))
                mmem[i][midx(ld_addr, mbase(i))] = ld_data;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("model_gnt%0d", i), {31'b0, gnt[i]}, {31'b0, eg[i]});
                chk($sformatf("model_dat%0d", i), dat[i], ed[i]);
                chk($sformatf("model_flt%0d", i), {31'b0, flt[i]}, {31'b0, ef[i]});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed table for the W=0 instance ----------------
    typedef struct {
        logic        rq;
        logic [31:0] ra;
        logic        le;
        logic [31:0] la;
        logic [31:0] ldd;
        logic        eg;
        logic        cd;
        logic [31:0] ed;
        logic        ef;
    } vec_t;
    vec_t tbl[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] raddr();
        logic [31:0] w;
        w = 32'($urandom_range(0, 'h43F)) << 2;
        case ($urandom_range(0, 9))
            0: return $urandom;
            1: return w | 32'($urandom_range(1, 3));
            2: return 32'hFFFF_FFFC;
            default: return w;
        endcase
    endfunction

    initial begin
        rstz = 1'b0; req = 1'b1; addr = 32'h0;
        ld_en = 1'b0; ld_addr = 32'h0; ld_data = 32'h0;

        // Preload every word of all three windows while held in reset, with req=1.
        for (int a = 0; a <= 'h10FC; a += 4) begin
            ld_en = 1'b1; ld_addr = 32'(a); ld_data = $urandom;
            step();
            chk_on = 1;
            if (a < 12) begin
                for (int i = 0; i < 3; i++) begin
                    chk("rst_gnt", {31'b0, gnt[i]}, 32'h0);
                    chk("rst_dat", dat[i], 32'h0);
                    chk("rst_flt", {31'b0, flt[i]}, 32'h0);
                end
            end
        end
        ld_en = 1'b0;

        // First grant after reset release: 1+W cycles.
        rstz = 1'b1; req = 1'b1; addr = 32'h0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rel_gnt0", {31'b0, gnt[0]}, 32'h1);
            chk("rel_gnt1", {31'b0, gnt[1]}, (k == 2) ? 32'h1 : 32'h0);
            chk("rel_gnt2", {31'b0, gnt[2]}, (k == 3) ? 32'h1 : 32'h0);
        end
        chk("rel_flt2", {31'b0, flt[2]}, 32'h1);
        chk("rel_dat2", dat[2], 32'h13);
        req = 1'b0;
        repeat (6) step();

        tbl.push_back(vec_t'{0, 32'h0,  1, 32'h0,   32'h11,       0, 0, 32'h0,        0});
        tbl.push_back(vec_t'{0, 32'h0,  1, 32'h4,   32'h22,       0, 0, 32'h0,        0});
        tbl.push_back(vec_t'{0, 32'h0,  1, 32'h8,   32'h33,       0, 0, 32'h0,        0});
        tbl.push_back(vec_t'{0, 32'h0,  1, 32'hC,   32'h44,       0, 0, 32'h0,        0});
        tbl.push_back(vec_t'{0, 32'h0,  1, 32'hFFC, 32'hCAFEF00D, 0, 0, 32'h0,        0});
        tbl.push_back(vec_t'{1, 32'h0,  0, 32'h0,   32'h0,        1, 1, 32'h11,       0});
        tbl.push_back(vec_t'{1, 32'h4,  0, 32'h0,   32'h0,        1, 1, 32'h22,       0});
        tbl.push_back(vec_t'{1, 32'h8,  0, 32'h0,   32'h0,        1, 1, 32'h33,       0});
        tbl.push_back(vec_t'{1, 32'hC,  0, 32'h0,   32'h0,        1, 1, 32'h44,       0});
        tbl.push_back(vec_t'{0, 32'h0,  0, 32'h0,   32'h0,        0, 1, 32'h44,       0});
        tbl.push_back(vec_t'{1, 32'h2,  0, 32'h0,   32'h0,        1, 1, 32'h13,       1});
        tbl.push_back(vec_t'{1, 32'h1000, 0, 32'h0, 32'h0,        1, 1, 32'h13,       1});
        tbl.push_back(vec_t'{1, 32'hFFC, 0, 32'h0,  32'h0,        1, 1, 32'hCAFEF00D, 0});
        tbl.push_back(vec_t'{1, 32'h4,  1, 32'h4,   32'hAA,       1, 1, 32'h22,       0});
        tbl.push_back(vec_t'{1, 32'h4,  0, 32'h0,   32'h0,        1, 1, 32'hAA,       0});
        tbl.push_back(vec_t'{0, 32'h0,  1, 32'h6,   32'hBB,       0, 1, 32'hAA,       0});
        tbl.push_back(vec_t'{1, 32'h4,  0, 32'h0,   32'h0,        1, 1, 32'hAA,       0});
        tbl.push_back(vec_t'{0, 32'h0,  1, 32'h1004, 32'h77,      0, 1, 32'hAA,       0});
        tbl.push_back(vec_t'{1, 32'h4,  0, 32'h0,   32'h0,        1, 1, 32'hAA,       0});
        tbl.push_back(vec_t'{1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0,   1, 1, 32'h13,       1});

        foreach (tbl[n]) begin
            req = tbl[n].rq; addr = tbl[n].ra;
            ld_en = tbl[n].le; ld_addr = tbl[n].la; ld_data = tbl[n].ldd;
            step();
            chk($sformatf("tbl%0d_gnt", n), {31'b0, gnt[0]}, {31'b0, tbl[n].eg});
            chk($sformatf("tbl%0d_flt", n), {31'b0, flt[0]}, {31'b0, tbl[n].ef});
            if (tbl[n].cd) chk($sformatf("tbl%0d_dat", n), dat[0], tbl[n].ed);
        end
        req = 1'b0; ld_en = 1'b0;
        repeat (6) step();

        // W=2: requests during WAIT are ignored; a request held through the grant is accepted.
        req = 1'b1; addr = 32'h4;
        step();
        chk("w2_n0", {31'b0, gnt[1]}, 32'h0);
        addr = 32'h8;
        step();
        chk("w2_n1", {31'b0, gnt[1]}, 32'h0);
        step();
        chk("w2_n2_gnt", {31'b0, gnt[1]}, 32'h1);
        chk("w2_n2_dat", dat[1], 32'hAA);
        step();
        chk("w2_n3", {31'b0, gnt[1]}, 32'h0);
        req = 1'b0;
        step();
        chk("w2_n4", {31'b0, gnt[1]}, 32'h0);
        step();
        chk("w2_n5_gnt", {31'b0, gnt[1]}, 32'h1);
        chk("w2_n5_dat", dat[1], 32'h33);
        step();
        chk("w2_n6", {31'b0, gnt[1]}, 32'h0);
        repeat (4) step();

        // BASE-4 on the BASE=0x100 instance faults.
        req = 1'b1; addr = 32'hFC;
        step();
        req = 1'b0;
        step(); step(); step();
        chk("below_base_gnt", {31'b0, gnt[2]}, 32'h1);
        chk("below_base_flt", {31'b0, flt[2]}, 32'h1);
        chk("below_base_dat", dat[2], 32'h13);
        repeat (3) step();

        // W=3: reset one cycle after capture discards the request.
        ld_en = 1'b1; ld_addr = 32'h104; ld_data = 32'h1234_5678;
        step();
        ld_en = 1'b0; req = 1'b1; addr = 32'h104;
        step();
        chk("mid_rst_n0", {31'b0, gnt[2]}, 32'h0);
        req = 1'b0;
        step();
        chk("mid_rst_n1", {31'b0, gnt[2]}, 32'h0);
        rstz = 1'b0;
        step();
        chk("mid_rst_n2", {31'b0, gnt[2]}, 32'h0);
        rstz = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("mid_rst_after", {31'b0, gnt[2]}, 32'h0);
        end
        req = 1'b1;
        step();
        req = 1'b0;
        step();
        chk("post_rst_m1", {31'b0, gnt[2]}, 32'h0);
        step();
        chk("post_rst_m2", {31'b0, gnt[2]}, 32'h0);
        step();
        chk("post_rst_gnt", {31'b0, gnt[2]}, 32'h1);
        chk("post_rst_dat", dat[2], 32'h1234_5678);
        chk("post_rst_flt", {31'b0, flt[2]}, 32'h0);
        repeat (3) step();

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            rstz    = ($urandom_range(0, 63) != 0);
            req     = ($urandom_range(0, 2) != 0);
            addr    = raddr();
            ld_en   = ($urandom_range(0, 3) == 0);
            ld_addr = raddr();
            ld_data = $urandom;
            step();
        end
        rstz = 1'b1; req = 1'b0; ld_en = 1'b0;
        repeat (6) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/kronos_imem_responder.md
Name: kronos_imem_responder

Overview:
Memory-side responder for the core's instruction-fetch interface (instr_addr/instr_req/instr_gnt/instr_data). It owns a word-organised instruction RAM. It samples fetch requests and returns the addressed word one or more cycles later with a one-cycle grant pulse, and it inserts a configurable number of wait states to model slow memory. A side-band load port lets a bootloader or bench write program words.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array (power of 2, >=2)
BASE_ADDR, 32'h0, byte address of word 0 (aligned to DEPTH_WORDS*4)
WAIT_STATES, 0, extra cycles between request capture and grant (0..15)
FAULT_DATA, 32'h0000_0013, word returned on a faulting fetch (RV32I NOP)

Ports:
clk  in  1  clock
rstz  in  1  synchronous active-low reset
instr_addr  in  32  fetch byte address
instr_req  in  1  fetch request; sampled with instr_addr on the rising edge
instr_gnt  out  1  one-cycle pulse; instr_data is valid for the captured request
instr_data  out  32  returned instruction word
fetch_fault  out  1  pulses with instr_gnt when the captured address was misaligned or out of range
load_en  in  1  program-load write strobe
load_addr  in  32  program-load byte address
load_data  in  32  program-load word

Behaviour:
- Reset (rstz low at a rising edge): state=IDLE, wait counter=0, instr_gnt=0, instr_data=0, fetch_fault=0. Any in-flight request is discarded and no grant follows. Array contents are not cleared.
- States: IDLE, WAIT, RESP.
- Capture: a request is accepted at an edge where instr_req=1 and state is IDLE or RESP. At that edge the address is registered and the fault check is evaluated.
- Fault check: fault if addr[1:0]!=0, if addr<BASE_ADDR, or if (addr-BASE_ADDR)>>2 >= DEPTH_WORDS. Otherwise index=(addr-BASE_ADDR)>>2, truncated to log2(DEPTH_WORDS) bits.
- WAIT_STATES=0: on accept, go to RESP. In RESP: instr_gnt=1, instr_data=mem[index] (or FAULT_DATA), fetch_fault=fault.
- WAIT_STATES=W>0: on accept, go to WAIT with counter=W-1. In WAIT, decrement each cycle. When the counter is 0, go to RESP on the next edge. Grant is therefore in cycle N+1+W for a capture at edge N.
- RESP exit: stay in RESP if a new request is accepted at this edge (back-to-back, sustained throughput of 1 word per cycle at W=0). Go to WAIT if W>0. Go to IDLE if instr_req=0.
- instr_req is ignored while in WAIT. The requester re-presents the address after an unconsumed grant; the responder treats that as a new request.
- Array read is registered and performed on the edge that enters RESP. instr_data holds its last value whenever instr_gnt=0. fetch_fault is 0 whenever instr_gnt=0.
- The grant is not held: if the requester is not ready in the RESP cycle, the word is dropped and the requester must re-request.
- Load port: on an edge with load_en=1 and an aligned, in-range load_addr, write load_data. Misaligned or out-of-range loads are silently dropped. Loads are accepted in any state.
- Read/write collision: if a load and the array read hit the same index on the same edge, the read returns the old word (read-first). The new word is visible from the next read onward.
- Address arithmetic is unsigned 32-bit. The index wraps within log2(DEPTH_WORDS) bits only after the range check passes, so no aliasing of out-of-range addresses.

Test Plan:
- Reset/idle: hold rstz=0 for 3 cycles with instr_req=1 -> instr_gnt=0, instr_data=0, fetch_fault=0 throughout. First grant arrives exactly 1+WAIT_STATES cycles after the first edge with rstz=1.
- Streaming, W=0, BASE_ADDR=0: load 0x0..0xC with 0x11,0x22,0x33,0x44. Present 0x0,0x4,0x8,0xC on consecutive edges with req=1 -> gnt high for 4 consecutive cycles with data 0x11,0x22,0x33,0x44.
- Wait states, W=2: request 0x4 -> gnt exactly 3 cycles later with data 0x22. Requests presented during WAIT are not granted. A re-request held through the grant cycle is accepted at that edge.
- Faults, DEPTH_WORDS=1024: request 0x2 -> gnt with data 0x00000013, fault=1. Request 0x1000 -> same. Request BASE_ADDR-4 with BASE_ADDR=0x100 -> same. Request 0xFFC -> fault=0.
- Collision: load 0x4=0xAA on the same edge that a read of 0x4 is captured (W=0) -> grant returns 0x22. The next read of 0x4 returns 0xAA.
- Reset mid-operation, W=3: accept a request, assert rstz=0 one cycle later for one cycle, then release with req=0 -> no grant is ever issued for the discarded request, and state returns to IDLE.
